// File: rtl/shift_reg_iter.sv
// ============================================================================
// shift_reg_iter : WIDTH-bit enabled register with an ITER-step shift mode
// Revision 1.0
// ============================================================================
`default_nettype none

module shift_reg_iter #(
  parameter int WIDTH = 64,
  parameter int SHIFT = 1,
  parameter int ITER  = 32,
  parameter int ARITH = 1,
  parameter int CW    = $clog2(ITER + 1)
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic [WIDTH-1:0] data_in_i,
  input  logic             writeEnable_i,
  input  logic             start_i,
  input  logic             dir_i,
  input  logic             stall_i,
  input  logic [SHIFT-1:0] serial_in_i,
  output logic [WIDTH-1:0] data_out_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CW-1:0]    count_o
);

  localparam logic [CW-1:0] C_LAST = CW'(ITER - 1);

  logic [WIDTH-1:0] data_q, data_d;
  logic [CW-1:0]    count_q, count_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dir_q, dir_d;

  logic [SHIFT-1:0] w_fill;
  logic [WIDTH-1:0] w_left;
  logic [WIDTH-1:0] w_right;

  assign w_fill  = (ARITH != 0) ? {SHIFT{data_q[WIDTH-1]}} : serial_in_i;
  assign w_left  = {data_q[WIDTH-SHIFT-1:0], serial_in_i};
  assign w_right = {w_fill, data_q[WIDTH-1:SHIFT]};

  // done is a pulse: it only survives an edge that completes another operation
  always_comb begin
    data_d  = data_q;
    count_d = count_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    dir_d   = dir_q;
    if (start_i) begin
      data_d  = data_in_i;
      dir_d   = dir_i;
      count_d = '0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (!stall_i) begin
        data_d  = dir_q ? w_left : w_right;
        count_d = count_q + CW'(1);
        if (count_q == C_LAST) begin
          busy_d = 1'b0;
          done_d = 1'b1;
        end
      end
    end else if (writeEnable_i) begin
      data_d = data_in_i;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      data_q  <= '0;
      count_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      dir_q   <= 1'b0;
    end else begin
      data_q  <= data_d;
      count_q <= count_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      dir_q   <= dir_d;
    end
  end

  assign data_out_o = data_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign count_o    = count_q;

endmodule

`default_nettype wire

// File: tb/tb_shift_reg_iter.sv
// ============================================================================
// tb_shift_reg_iter : directed self-checking bench for shift_reg_iter
// Revision 1.0
// ============================================================================
`default_nettype none

module tb_shift_reg_iter;

  logic        clk = 1'b0;
  logic        reset;
  logic [63:0] data_in;
  logic        writeEnable;
  logic        start;
  logic        dir;
  logic        stall;
  logic        serial_a;
  logic [1:0]  serial_b;

  logic [63:0] data_a, data_b;
  logic        busy_a, busy_b, done_a, done_b;
  logic [2:0]  count_a, count_b;

  int checks = 0;
  int errors = 0;
  logic [63:0] sb_a[$];
  logic [63:0] sb_b[$];

  always #5 clk = ~clk;

  shift_reg_iter #(.WIDTH(64), .SHIFT(1), .ITER(4), .ARITH(1)) u_a (
    .clk_i(clk), .reset_i(reset), .data_in_i(data_in), .writeEnable_i(writeEnable),
    .start_i(start), .dir_i(dir), .stall_i(stall), .serial_in_i(serial_a),
    .data_out_o(data_a), .busy_o(busy_a), .done_o(done_a), .count_o(count_a));

  shift_reg_iter #(.WIDTH(64), .SHIFT(2), .ITER(4), .ARITH(0)) u_b (
    .clk_i(clk), .reset_i(reset), .data_in_i(data_in), .writeEnable_i(writeEnable),
    .start_i(start), .dir_i(dir), .stall_i(stall), .serial_in_i(serial_b),
    .data_out_o(data_b), .busy_o(busy_b), .done_o(done_b), .count_o(count_b));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Run DUT a until done (bounded), then compare against the scoreboard head.
  task automatic run_a(input string tag, input int exp_n);
    int  n = 0;
    bit  seen = 1'b0;
    logic [63:0] exp;
    while (n < 30 && !seen) begin
      tick();
      n++;
      seen = done_a;
    end
    chk({tag, "_latency"}, 64'(n), 64'(exp_n));
    if (seen && sb_a.size() > 0) begin
      exp = sb_a.pop_front();
      chk({tag, "_data"}, data_a, exp);
      chk({tag, "_count"}, 64'(count_a), 64'd4);
      chk({tag, "_busy"}, 64'(busy_a), 64'd0);
    end
  endtask

  initial begin
    bit          any_done;
    logic [63:0] exp;

    reset = 1'b1; data_in = '0; writeEnable = 1'b0; start = 1'b0;
    dir = 1'b0; stall = 1'b0; serial_a = 1'b0; serial_b = 2'b00;
    tick(); tick();
    chk("rst_data", data_a, 64'd0);
    chk("rst_busy", 64'(busy_a), 64'd0);
    chk("rst_done", 64'(done_a), 64'd0);
    chk("rst_count", 64'(count_a), 64'd0);

    // Test 1: legacy load then asynchronous reset mid-cycle
    reset = 1'b0; writeEnable = 1'b1; data_in = 64'hDEADBEEF_01234567;
    tick();
    writeEnable = 1'b0; data_in = 64'h5555_5555_5555_5555;
    tick();
    chk("load_data", data_a, 64'hDEADBEEF_01234567);
    chk("load_data_b", data_b, 64'hDEADBEEF_01234567);
    chk("load_busy", 64'(busy_a), 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("async_rst_data", data_a, 64'd0);
    tick();
    reset = 1'b0;

    // Test 2: arithmetic right shift on a, serial-fill right shift on b
    data_in = 64'h8000_0000_0000_0010; dir = 1'b0; start = 1'b1; serial_b = 2'b10;
    sb_a.push_back(64'hF800_0000_0000_0001);
    sb_b.push_back(64'hAA80_0000_0000_0000);
    tick();
    start = 1'b0;
    chk("t2_load", data_a, 64'h8000_0000_0000_0010);
    chk("t2_busy", 64'(busy_a), 64'd1);
    run_a("t2", 4);
    chk("t2_done_b", 64'(done_b), 64'd1);
    exp = sb_b.pop_front();
    chk("t2_data_b", data_b, exp);
    tick();
    chk("t2_done_pulse", 64'(done_a), 64'd0);
    chk("t2_count_hold", 64'(count_a), 64'd4);

    // Test 3: left shift with serial fill
    data_in = 64'h1; dir = 1'b1; start = 1'b1; serial_a = 1'b1; serial_b = 2'b11;
    sb_a.push_back(64'h1F);
    sb_b.push_back(64'h1FF);
    tick();
    start = 1'b0;
    run_a("t3", 4);
    exp = sb_b.pop_front();
    chk("t3_data_b", data_b, exp);
    chk("t3_count_b", 64'(count_b), 64'd4);

    // Test 4: stall for 3 cycles after the 2nd shift, writeEnable ignored
    data_in = 64'h8000_0000_0000_0010; dir = 1'b0; start = 1'b1;
    sb_a.push_back(64'hF800_0000_0000_0001);
    tick();
    start = 1'b0;
    tick(); tick();
    stall = 1'b1; writeEnable = 1'b1; data_in = 64'h1234;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_stall_data", data_a, 64'hE000_0000_0000_0004);
      chk("t4_stall_count", 64'(count_a), 64'd2);
    end
    stall = 1'b0; writeEnable = 1'b0;
    run_a("t4", 2);

    // Test 5a: restart after two shifts; aborted op must not complete
    data_in = 64'h8000_0000_0000_0010; dir = 1'b0; start = 1'b1;
    sb_a.push_back(64'hF800_0000_0000_0001);
    tick();
    start = 1'b0;
    tick(); tick();
    void'(sb_a.pop_back());
    data_in = 64'h4; dir = 1'b1; serial_a = 1'b1; start = 1'b1;
    sb_a.push_back(64'h4F);
    tick();
    start = 1'b0;
    chk("t5_restart_count", 64'(count_a), 64'd0);
    chk("t5_restart_data", data_a, 64'h4);
    chk("t5_restart_done", 64'(done_a), 64'd0);
    run_a("t5", 4);

    // Test 5b: reset at count=2, no done afterwards
    data_in = 64'h8000_0000_0000_0010; dir = 1'b0; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    chk("t5b_count", 64'(count_a), 64'd2);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("t5b_rst_data", data_a, 64'd0);
    chk("t5b_rst_busy", 64'(busy_a), 64'd0);
    chk("t5b_rst_count", 64'(count_a), 64'd0);
    tick();
    reset = 1'b0;
    any_done = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      any_done = any_done | done_a;
    end
    chk("t5b_no_done", 64'(any_done), 64'd0);

    // Test 6: back-to-back start on the done cycle
    data_in = 64'h8000_0000_0000_0010; dir = 1'b0; start = 1'b1;
    sb_a.push_back(64'hF800_0000_0000_0001);
    tick();
    start = 1'b0;
    run_a("t6a", 4);
    data_in = 64'h1; dir = 1'b1; serial_a = 1'b0; start = 1'b1;
    sb_a.push_back(64'h10);
    tick();
    start = 1'b0;
    chk("t6_done_clr", 64'(done_a), 64'd0);
    chk("t6_reload", data_a, 64'h1);
    chk("t6_busy", 64'(busy_a), 64'd1);
    chk("t6_count0", 64'(count_a), 64'd0);
    run_a("t6b", 4);

    chk("sb_empty", 64'(sb_a.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
